// File: rtl/ah_credit_snoop_issuer_pkg.sv
// Shared types and defaults for the credit/snoop issue stage in front of the
// snoopable FIFO.
package ah_issuer_pkg;

  localparam int DATA_W_DEF    = 132;
  localparam int KEY_W_DEF     = 16;
  localparam int CREDITS_DEF   = 20;
  localparam int RETRY_GAP_DEF = 4;

  typedef enum logic [2:0] {
    IDLE,
    SNOOP,
    CHECK,
    WAIT_CREDIT,
    BACKOFF
  } state_e;

  // Bits needed to hold the values 0..n inclusive (never less than one).
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/ah_credit_snoop_issuer_credit_counter.sv
// Write-credit pool mirroring the downstream FIFO depth; a return that would
// exceed the depth is dropped and latched as a sticky error.
module ah_credit_counter
  import ah_issuer_pkg::*;
#(
  parameter int CREDITS = CREDITS_DEF,
  parameter int CNT_W   = cnt_width(CREDITS)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(CREDITS);

  logic [CNT_W-1:0] count_q, count_d;
  logic             err_q, err_d;

  always_comb begin
    count_d = count_q;
    err_d   = err_q;
    if (inc && !dec) begin
      if (count_q == MAX_CNT) begin
        err_d = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      count_q <= MAX_CNT;
      err_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign err   = err_q;

endmodule

// File: rtl/ah_credit_snoop_issuer.sv
// Issue stage: holds one request, snoops the FIFO for a same-key entry, backs
// off on a hit and pushes on a miss once a write credit is available.
module ah_credit_snoop_issuer
  import ah_issuer_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int KEY_W     = KEY_W_DEF,
  parameter int CREDITS   = CREDITS_DEF,
  parameter int RETRY_GAP = RETRY_GAP_DEF,
  parameter int CNT_W     = cnt_width(CREDITS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_credit,
  output logic [KEY_W-1:0]  snp_data,
  output logic              snp_valid,
  input  logic              snp_match,
  output logic [CNT_W-1:0]  credit_cnt,
  output logic              cred_err
);

  localparam int GAP_W = cnt_width(RETRY_GAP);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic              out_valid_q, out_valid_d;
  logic              send;
  logic              credit_avail;
  logic [CNT_W-1:0]  cnt;
  logic              err;

  ah_credit_counter #(
    .CREDITS (CREDITS),
    .CNT_W   (CNT_W)
  ) u_credit (
    .clk   (clk),
    .rstn  (rstn),
    .inc   (out_credit),
    .dec   (send),
    .count (cnt),
    .err   (err)
  );

  assign credit_avail = (cnt != '0);

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    send    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          hold_d  = in_data;
          state_d = SNOOP;
        end
      end
      SNOOP: state_d = CHECK;
      CHECK: begin
        if (snp_match) begin
          state_d = BACKOFF;
          gap_d   = GAP_W'(RETRY_GAP - 1);
        end else if (credit_avail) begin
          send    = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = WAIT_CREDIT;
        end
      end
      // A miss stays valid while parked: only drains can happen meanwhile.
      WAIT_CREDIT: begin
        if (credit_avail) begin
          send    = 1'b1;
          state_d = IDLE;
        end
      end
      BACKOFF: begin
        if (gap_q == '0) begin
          state_d = SNOOP;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    out_valid_d = send;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      hold_q      <= '0;
      gap_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign snp_valid  = (state_q == SNOOP);
  assign snp_data   = snp_valid ? hold_q[KEY_W-1:0] : '0;
  assign out_data   = hold_q;
  assign out_valid  = out_valid_q;
  assign credit_cnt = cnt;
  assign cred_err   = err;

endmodule

// File: tb/tb_ah_credit_snoop_issuer.sv
// Bench for ah_credit_snoop_issuer: transaction-level model checked every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_ah_credit_snoop_issuer;

  localparam int DATA_W    = 132;
  localparam int KEY_W     = 16;
  localparam int CREDITS   = 20;
  localparam int RETRY_GAP = 4;
  localparam int CNT_W     = 5;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_credit = 1'b0;
  logic [KEY_W-1:0]  snp_data;
  logic              snp_valid;
  logic              snp_match = 1'b0;
  logic [CNT_W-1:0]  credit_cnt;
  logic              cred_err;

  ah_credit_snoop_issuer #(
    .DATA_W(DATA_W), .KEY_W(KEY_W), .CREDITS(CREDITS), .RETRY_GAP(RETRY_GAP), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_credit(out_credit),
    .snp_data(snp_data), .snp_valid(snp_valid), .snp_match(snp_match),
    .credit_cnt(credit_cnt), .cred_err(cred_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  // Snoop responder: number of upcoming snoops to answer with a hit.
  int   hits_left  = 0;
  logic match_next = 1'b0;
  always @(posedge clk) begin
    #1;
    snp_match = match_next;
  end

  // Transaction-level model: what must be visible in each cycle.
  int                cyc = 0;
  bit                m_busy = 0, m_wait = 0, m_err = 0;
  logic [DATA_W-1:0] m_hold = '0;
  int                exp_snoop = -1, exp_push = -1, chk_cyc = -1;
  int                m_cred = CREDITS;

  always @(negedge clk) begin
    bit send_now, busy_now;
    cyc++;
    if (!rstn) begin
      m_busy = 0; m_wait = 0; m_err = 0; m_hold = '0;
      exp_snoop = -1; exp_push = -1; chk_cyc = -1; m_cred = CREDITS;
    end
    check("mon_in_ready", in_ready, !m_busy);
    check("mon_snp_valid", snp_valid, cyc == exp_snoop);
    check("mon_snp_data", snp_data, (cyc == exp_snoop) ? m_hold[KEY_W-1:0] : '0);
    check("mon_out_valid", out_valid, cyc == exp_push);
    check("mon_out_data", out_data, m_hold);
    check("mon_credit_cnt", credit_cnt, m_cred);
    check("mon_cred_err", cred_err, m_err);

    match_next = snp_valid && (hits_left > 0);
    if (match_next) hits_left--;

    if (rstn) begin
      send_now = 0;
      busy_now = m_busy;
      if (cyc == chk_cyc) begin
        if (snp_match) exp_snoop = cyc + 1 + RETRY_GAP;
        else if (m_cred > 0) send_now = 1;
        else m_wait = 1;
      end else if (m_wait && m_cred > 0) begin
        send_now = 1;
      end
      if (send_now) begin
        exp_push = cyc + 1; m_busy = 0; m_wait = 0;
      end
      if (!busy_now && in_valid) begin
        m_hold = in_data; m_busy = 1; exp_snoop = cyc + 1;
      end
      if (cyc == exp_snoop) chk_cyc = cyc + 1;
      if (out_credit && !send_now) begin
        if (m_cred == CREDITS) m_err = 1;
        else m_cred++;
      end else if (send_now && !out_credit) begin
        m_cred--;
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    rstn = 1'b0; in_valid = 1'b0; out_credit = 1'b0; hits_left = 0;
    step(2);
    rstn = 1'b1;
    step(1);
  endtask

  // Returns one cycle after the accepting edge (the SNOOP cycle).
  task automatic send_req(input logic [DATA_W-1:0] d);
    int n = 0;
    bit got = 0;
    in_valid = 1'b1; in_data = d;
    while (!got && n < 60) begin
      @(negedge clk);
      got = in_ready;
      n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!got) check("accept_timeout", 0, 1);
  endtask

  initial begin
    int snoops[$];
    int npush, nsnp;
    logic [DATA_W-1:0] d;

    // Single miss request.
    do_reset();
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_credit", credit_cnt, 20);
    check("rst_out_valid", out_valid, 0);
    @(posedge clk); #1;
    d = {116'h123, 16'hABCD};
    send_req(d);
    @(negedge clk);
    check("t1_snp_valid", snp_valid, 1);
    check("t1_snp_data", snp_data, 16'hABCD);
    @(negedge clk);
    check("t1_no_push_yet", out_valid, 0);
    @(negedge clk);
    check("t1_out_valid", out_valid, 1);
    check("t1_out_data", out_data, d);
    check("t1_credit", credit_cnt, 19);
    check("t1_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Exhaust credits, then park in WAIT_CREDIT.
    do_reset();
    for (int i = 0; i < 20; i++) send_req(DATA_W'(32'h1000 + i * 7));
    step(3);
    @(negedge clk);
    check("t2_credit_zero", credit_cnt, 0);
    @(posedge clk); #1;
    send_req(DATA_W'(32'h5555));
    step(4);
    @(negedge clk);
    check("t2_parked_ready", in_ready, 0);
    check("t2_parked_no_push", out_valid, 0);
    @(posedge clk); #1;
    out_credit = 1'b1;
    step(1);
    out_credit = 1'b0;
    @(negedge clk);
    check("t2_credit_one", credit_cnt, 1);
    check("t2_push_not_yet", out_valid, 0);
    @(negedge clk);
    check("t2_push", out_valid, 1);
    check("t2_credit_back0", credit_cnt, 0);
    @(posedge clk); #1;

    // Two hits then a miss.
    do_reset();
    hits_left = 2;
    send_req({116'h0, 16'h0BEE});
    snoops.delete();
    npush = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (snp_valid) snoops.push_back(k);
      if (out_valid) npush++;
    end
    check("t3_snoop_count", snoops.size(), 3);
    if (snoops.size() == 3) begin
      check("t3_gap1", snoops[1] - snoops[0], 6);
      check("t3_gap2", snoops[2] - snoops[1], 6);
    end
    check("t3_push_count", npush, 1);
    @(posedge clk); #1;

    // Return and send on the same edge at 5 credits.
    do_reset();
    for (int i = 0; i < 15; i++) send_req(DATA_W'(32'h2000 + i));
    step(3);
    @(negedge clk);
    check("t4_credit5", credit_cnt, 5);
    @(posedge clk); #1;
    send_req(DATA_W'(32'h7777));
    step(1);
    out_credit = 1'b1;
    step(1);
    out_credit = 1'b0;
    @(negedge clk);
    check("t4_push", out_valid, 1);
    check("t4_credit_same", credit_cnt, 5);
    check("t4_no_err", cred_err, 0);
    @(posedge clk); #1;

    // Overflow return while full.
    do_reset();
    out_credit = 1'b1;
    step(1);
    out_credit = 1'b0;
    @(negedge clk);
    check("t5_credit_full", credit_cnt, 20);
    check("t5_err_set", cred_err, 1);
    @(posedge clk); #1;
    send_req(DATA_W'(32'h3333));
    step(4);
    @(negedge clk);
    check("t5_err_sticky", cred_err, 1);
    check("t5_credit19", credit_cnt, 19);
    @(posedge clk); #1;

    // Reset asserted during BACKOFF.
    do_reset();
    hits_left = 100;
    send_req(DATA_W'(32'h4444));
    step(3);
    @(negedge clk);
    check("t6_in_backoff_ready", in_ready, 0);
    @(posedge clk); #1;
    rstn = 1'b0;
    hits_left = 0;
    @(negedge clk);
    check("t6_rst_ready", in_ready, 1);
    check("t6_rst_credit", credit_cnt, 20);
    @(posedge clk); #1;
    rstn = 1'b1;
    npush = 0; nsnp = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) npush++;
      if (snp_valid) nsnp++;
    end
    check("t6_no_push", npush, 0);
    check("t6_no_snoop", nsnp, 0);
    check("t6_ready", in_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ah_credit_snoop_issuer.md
# ah_credit_snoop_issuer

Upstream issue stage for the 132-bit snoopable FIFO: accepts requests over valid/ready, snoops the FIFO with the request's low 16-bit key to block same-key hazards, and forwards the request only when no match exists and a write credit is held. It owns the credit pool that mirrors the FIFO depth, consuming one credit per push and regaining one per credit-return pulse.

## Interface
- DATA_W, 132, request/FIFO entry width
- KEY_W, 16, snoop key width = in_data[KEY_W-1:0]
- CREDITS, 20, initial credits = downstream FIFO depth
- RETRY_GAP, 4, back-off cycles after a snoop hit (>=1)
- CNT_W, $clog2(CREDITS+1), credit counter width (derived)

- clk  in  1  clock
- rstn  in  1  reset; asynchronous, active-low
- in_data  in  DATA_W  request payload
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready
- out_data  out  DATA_W  to FIFO wdata
- out_valid  out  1  to FIFO wvalid; one-cycle push pulse
- out_credit  in  1  from FIFO wcredit; one pulse = one credit returned
- snp_data  out  KEY_W  to FIFO sdata
- snp_valid  out  1  to FIFO svalid; one-cycle pulse
- snp_match  in  1  from FIFO smatch; valid the cycle after snp_valid
- credit_cnt  out  CNT_W  current credits
- cred_err  out  1  sticky credit-overflow flag

## Operation
- Single holding register `hold`; out_data = hold, snp_data = hold[KEY_W-1:0] while in SNOOP, else 0.
- FSM: IDLE, SNOOP, CHECK, WAIT_CREDIT, BACKOFF.
- IDLE: in_ready=1. On accept: hold<=in_data, -> SNOOP.
- SNOOP: snp_valid=1 for exactly one cycle -> CHECK.
- CHECK: sample snp_match. Hit -> BACKOFF, gap<=RETRY_GAP-1. Miss and credit_cnt>0 -> send, -> IDLE. Miss and credit_cnt==0 -> WAIT_CREDIT.
- WAIT_CREDIT: when credit_cnt>0 -> send, -> IDLE. No re-snoop (only drains occur while waiting; a miss stays valid).
- BACKOFF: gap decrements each cycle; at gap==0 -> SNOOP. Repeats indefinitely while hits persist.
- Send: out_valid registered high for the one cycle following the decision edge; credit_cnt decrements on that same edge.
- Credit counter: -1 on send, +1 on out_credit; both in one cycle -> unchanged. Return arriving while credit_cnt==CREDITS and no send: counter holds CREDITS, cred_err<=1 (sticky until reset).
- out_credit is honoured in every state, including reset release cycle onward.

## Timing
- Reset values: in_ready=1 (IDLE), out_valid=0, out_data=0, snp_valid=0, snp_data=0, credit_cnt=CREDITS, cred_err=0, gap=0.
- Accept at edge E0 -> snp_valid high cycle after E0 -> snp_match sampled next cycle -> out_valid high the following cycle with in_ready=1. Miss path latency 3 cycles accept-to-push; max throughput 1 request / 3 cycles.
- Hit path: RETRY_GAP BACKOFF cycles, then new SNOOP; total per retry RETRY_GAP+2 cycles.
- WAIT_CREDIT: credit pulse at edge Ec makes credit_cnt>0 after Ec; out_valid high cycle after next edge.
- New accept in the cycle out_valid=1 is legal; FIFO samples out_data at the edge that overwrites hold.
- rstn assertion mid-operation: held request discarded, no out_valid/snp_valid emitted, counter restored to CREDITS.

## Structure
- Package ah_issuer_pkg: state enum (IDLE, SNOOP, CHECK, WAIT_CREDIT, BACKOFF), default parameter constants, CNT_W derivation function.
- Sub-module ah_credit_counter (inc, dec, count, overflow err); FSM, hold register and gap counter in top.

## Test plan
- Reset, single request 0x…ABCD, snp_match=0 -> snp_valid with snp_data=16'hABCD one cycle after accept, out_valid 3 cycles after accept, credit_cnt 20->19.
- 20 back-to-back misses, no returns -> 20 pushes, credit_cnt=0; 21st parks in WAIT_CREDIT, in_ready=0; one out_credit pulse -> push follows, credit_cnt back to 0.
- snp_match=1 on first two snoops, 0 on third -> three snp_valid pulses spaced RETRY_GAP+2=6 cycles, exactly one out_valid.
- out_credit and send in same cycle at credit_cnt=5 -> credit_cnt stays 5, cred_err=0.
- out_credit pulse at credit_cnt=20 idle -> credit_cnt=20, cred_err=1 and stays 1.
- rstn low during BACKOFF -> no out_valid afterward, credit_cnt=20, in_ready=1 on release.
